// File: rtl/jt1943_scrrom_pkg.sv
// Shared types and constants for the 1943 scroll ROM server.
// Defines the FSM states, the channel ids and the default ROM offsets.
package jt1943_scrrom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic CH_MAP = 1'b0;
  localparam logic CH_GFX = 1'b1;

  localparam int unsigned MAP_AW   = 14;
  localparam int unsigned GFX_AW   = 17;
  localparam int unsigned SDRAM_AW = 22;
  localparam int unsigned DW       = 16;

  localparam logic [SDRAM_AW-1:0] DEF_MAP_OFFSET = 22'h00000;
  localparam logic [SDRAM_AW-1:0] DEF_GFX_OFFSET = 22'h08000;

endpackage

// File: rtl/jt1943_scrrom_server_if.sv
// SDRAM arbiter request/response bus as seen by one scroll ROM server.
interface jt1943_scrrom_server_if;
  import jt1943_scrrom_pkg::*;

  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                data_rdy;
  logic [DW-1:0]       sdram_din;

  modport master (
    output sdram_req, sdram_addr,
    input  sdram_ack, data_rdy, sdram_din
  );

  modport slave (
    input  sdram_req, sdram_addr,
    output sdram_ack, data_rdy, sdram_din
  );
endinterface

// File: rtl/jt1943_scrrom_slot.sv
// One cached ROM word: valid/tag/data registers with a combinational hit
// compare against the address currently requested by the scroll generator.
module jt1943_scrrom_slot
  import jt1943_scrrom_pkg::*;
#(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [AW-1:0] wtag,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] data,
  output logic          hit
);

  logic          valid;
  logic [AW-1:0] tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (we) begin
      valid <= 1'b1;
      tag   <= wtag;
      data  <= wdata;
    end
  end

  assign hit = valid && (tag == addr);

endmodule

// File: rtl/jt1943_scrrom_server.sv
// Scroll-layer ROM server: caches one tile-map word and one graphics word,
// refilling misses through the shared SDRAM request port.
module jt1943_scrrom_server
  import jt1943_scrrom_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] MAP_OFFSET = DEF_MAP_OFFSET,
  parameter logic [SDRAM_AW-1:0] GFX_OFFSET = DEF_GFX_OFFSET
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs,
  input  logic [MAP_AW-1:0]      map_addr,
  output logic [DW-1:0]          map_data,
  output logic                   map_ok,
  input  logic [GFX_AW-1:0]      scr_addr,
  output logic [DW-1:0]          scrom_data,
  output logic                   scr_ok,
  jt1943_scrrom_server_if.master sdram
);

  state_t              state, state_nxt;
  logic                sel_ch;
  logic                rr_next;
  logic [GFX_AW-1:0]   lat_addr;
  logic [SDRAM_AW-1:0] addr_q;

  logic                grant, contest, pick;
  logic [GFX_AW-1:0]   pick_addr;
  logic [SDRAM_AW-1:0] req_addr;
  logic                wr_map, wr_gfx;
  logic                map_miss, gfx_miss;

  assign map_miss = !map_ok;
  assign gfx_miss = !scr_ok;
  assign contest  = map_miss && gfx_miss;

  jt1943_scrrom_slot #(.AW(MAP_AW)) u_map (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (map_addr),
    .we    (wr_map),
    .wtag  (lat_addr[MAP_AW-1:0]),
    .wdata (sdram.sdram_din),
    .data  (map_data),
    .hit   (map_ok)
  );

  jt1943_scrrom_slot #(.AW(GFX_AW)) u_gfx (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (scr_addr),
    .we    (wr_gfx),
    .wtag  (lat_addr),
    .wdata (sdram.sdram_din),
    .data  (scrom_data),
    .hit   (scr_ok)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pick      = CH_GFX;
    wr_map    = 1'b0;
    wr_gfx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs && (map_miss || gfx_miss)) begin
          grant     = 1'b1;
          state_nxt = REQ;
          if (contest) pick = rr_next;
          else         pick = map_miss ? CH_MAP : CH_GFX;
        end
      end
      REQ: begin
        if (sdram.sdram_ack) state_nxt = WAIT;
      end
      WAIT: begin
        if (sdram.data_rdy) begin
          state_nxt = IDLE;
          wr_map    = (sel_ch == CH_MAP);
          wr_gfx    = (sel_ch == CH_GFX);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pick_addr = (pick == CH_MAP) ? {{(GFX_AW-MAP_AW){1'b0}}, map_addr} : scr_addr;
    req_addr  = ((pick == CH_MAP) ? MAP_OFFSET : GFX_OFFSET)
              + {{(SDRAM_AW-GFX_AW){1'b0}}, pick_addr};
  end

  // The round-robin pointer only moves when both channels competed, so an
  // uncontested follow-up refill does not take the next contest away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_ch   <= CH_MAP;
      rr_next  <= CH_GFX;
      lat_addr <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        sel_ch   <= pick;
        lat_addr <= pick_addr;
        addr_q   <= req_addr;
        if (contest) rr_next <= (pick == CH_MAP) ? CH_GFX : CH_MAP;
      end
    end
  end

  assign sdram.sdram_req  = (state == REQ);
  assign sdram.sdram_addr = addr_q;

endmodule

// File: tb/tb_jt1943_scrrom_server.sv
// Directed bench for jt1943_scrrom_server with a scoreboard of expected
// SDRAM transactions and a second instance exercising offset wrap-around.
module tb_jt1943_scrrom_server;
  import jt1943_scrrom_pkg::*;

  typedef struct {
    logic [21:0] addr;
    logic [15:0] data;
    logic        ch;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs = 1'b0;
  logic [13:0] map_addr = '0;
  logic [16:0] scr_addr = '0;
  logic [15:0] map_data, scrom_data;
  logic        map_ok, scr_ok;
  logic [15:0] w_map_data, w_scr_data;
  logic        w_map_ok, w_scr_ok;

  int   n_chk = 0;
  int   n_err = 0;
  txn_t sb[$];
  txn_t cur;
  logic timed_out;

  jt1943_scrrom_server_if bus ();
  jt1943_scrrom_server_if bus_w ();

  jt1943_scrrom_server u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .map_addr   (map_addr),
    .map_data   (map_data),
    .map_ok     (map_ok),
    .scr_addr   (scr_addr),
    .scrom_data (scrom_data),
    .scr_ok     (scr_ok),
    .sdram      (bus)
  );

  jt1943_scrrom_server #(.GFX_OFFSET(22'h3F0000)) u_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (1'b1),
    .map_addr   (14'h0000),
    .map_data   (w_map_data),
    .map_ok     (w_map_ok),
    .scr_addr   (17'h1FFFF),
    .scrom_data (w_scr_data),
    .scr_ok     (w_scr_ok),
    .sdram      (bus_w)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [21:0] a, input logic [15:0] d, input logic ch);
    txn_t t;
    t.addr = a;
    t.data = d;
    t.ch   = ch;
    sb.push_back(t);
  endtask

  // Wait for the next request, expect it exactly one cycle after the call.
  task automatic issue_check(input string tag);
    int w;
    w = 0;
    timed_out = 1'b0;
    while (bus.sdram_req !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk({tag, ".latency"}, w, 1);
    chk({tag, ".sb_nonempty"}, sb.size() > 0, 1);
    if (w >= 20 || sb.size() == 0) begin
      timed_out = 1'b1;
      return;
    end
    cur = sb.pop_front();
    chk({tag, ".addr"}, bus.sdram_addr, cur.addr);
  endtask

  task automatic finish_txn(input int ack_dly, input int rdy_dly, input string tag,
                            input logic chg, input logic [16:0] new_scr);
    if (timed_out) return;
    repeat (ack_dly) begin
      tick();
      chk({tag, ".req_hold"}, bus.sdram_req, 1'b1);
      chk({tag, ".addr_hold"}, bus.sdram_addr, cur.addr);
    end
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    chk({tag, ".req_drop"}, bus.sdram_req, 1'b0);
    if (chg) scr_addr = new_scr;
    repeat (rdy_dly - 1) tick();
    bus.sdram_din = cur.data;
    bus.data_rdy  = 1'b1;
    tick();
    bus.data_rdy  = 1'b0;
    bus.sdram_din = '0;
    chk({tag, ".data"}, (cur.ch == CH_MAP) ? map_data : scrom_data, cur.data);
  endtask

  task automatic serve(input int ack_dly, input int rdy_dly, input string tag);
    issue_check(tag);
    finish_txn(ack_dly, rdy_dly, tag, 1'b0, '0);
  endtask

  initial begin
    bus.sdram_ack   = 1'b0;
    bus.data_rdy    = 1'b0;
    bus.sdram_din   = '0;
    bus_w.sdram_ack = 1'b0;
    bus_w.data_rdy  = 1'b0;
    bus_w.sdram_din = '0;
    cs       = 1'b0;
    map_addr = 14'h0123;
    scr_addr = 17'h00005;

    #2 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst.map_ok", map_ok, 1'b0);
    chk("rst.scr_ok", scr_ok, 1'b0);
    chk("rst.req", bus.sdram_req, 1'b0);
    chk("rst.addr", bus.sdram_addr, 22'h0);
    chk("rst.map_data", map_data, 16'h0);
    chk("rst.scr_data", scrom_data, 16'h0);

    // cs low blocks requests while both channels miss
    rst_n = 1'b1;
    repeat (3) tick();
    chk("cs_low.req", bus.sdram_req, 1'b0);
    chk("wrap.req", bus_w.sdram_req, 1'b1);
    chk("wrap.addr", bus_w.sdram_addr, 22'h00FFFF);

    // first contest after reset goes to gfx
    cs = 1'b1;
    push(22'h08005, 16'h5555, CH_GFX);
    push(22'h00123, 16'hBEEF, CH_MAP);
    serve(1, 3, "s1g");
    chk("s1g.scr_ok", scr_ok, 1'b1);
    serve(1, 3, "s1m");
    chk("s1m.map_ok", map_ok, 1'b1);
    repeat (3) begin
      tick();
      chk("s1.hit_no_req", bus.sdram_req, 1'b0);
    end
    chk("s1.hit_ok", map_ok, 1'b1);

    // second contest: map wins
    map_addr = 14'h0001;
    scr_addr = 17'h00002;
    push(22'h00001, 16'h1111, CH_MAP);
    push(22'h08002, 16'h2222, CH_GFX);
    serve(0, 1, "s2m");
    serve(2, 2, "s2g");
    chk("s2.map_ok", map_ok, 1'b1);
    chk("s2.scr_ok", scr_ok, 1'b1);

    // third contest: gfx again
    map_addr = 14'h0003;
    scr_addr = 17'h00004;
    push(22'h08004, 16'h4444, CH_GFX);
    push(22'h00003, 16'h3333, CH_MAP);
    serve(1, 2, "s3g");
    serve(0, 4, "s3m");
    chk("s3.map_data", map_data, 16'h3333);
    chk("s3.scr_data", scrom_data, 16'h4444);

    // address changes during WAIT: stale fill, then a fresh miss
    scr_addr = 17'h00005;
    push(22'h08005, 16'hAAAA, CH_GFX);
    push(22'h08006, 16'h6666, CH_GFX);
    issue_check("s4a");
    finish_txn(1, 3, "s4a", 1'b1, 17'h00006);
    chk("s4a.scr_ok", scr_ok, 1'b0);
    serve(1, 2, "s4b");
    chk("s4b.scr_ok", scr_ok, 1'b1);
    chk("s4.map_ok", map_ok, 1'b1);

    // reset in the middle of WAIT
    scr_addr = 17'h00009;
    push(22'h08009, 16'h9999, CH_GFX);
    issue_check("s5");
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("s5.rst_req", bus.sdram_req, 1'b0);
    chk("s5.rst_map_ok", map_ok, 1'b0);
    chk("s5.rst_scr_ok", scr_ok, 1'b0);
    tick();
    cs    = 1'b0;
    rst_n = 1'b1;
    bus.sdram_din = 16'h9999;
    bus.data_rdy  = 1'b1;
    tick();
    bus.data_rdy  = 1'b0;
    bus.sdram_din = '0;
    chk("s5.stray_data", scrom_data, 16'h0);
    chk("s5.stray_ok", scr_ok, 1'b0);
    chk("s5.stray_req", bus.sdram_req, 1'b0);

    cs = 1'b1;
    push(22'h08009, 16'h1234, CH_GFX);
    push(22'h00003, 16'h5678, CH_MAP);
    serve(1, 2, "s6g");
    serve(1, 2, "s6m");
    chk("s6.map_ok", map_ok, 1'b1);
    chk("s6.scr_ok", scr_ok, 1'b1);
    chk("end.sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
